// File: rtl/sram_like_slave.sv
// sram_like_slave: responder end of the sram-like req/addr_ok/data_ok
// interface. Accepts reads and writes into a word-addressed memory and
// returns one data_ok per accepted request, in order, LAT cycles after
// the address handshake, or later if an older response is still queued.
//
// Optional build macro: SRAM_SLV_RAND_DELAY_EN. When defined, an LFSR
// randomly stalls addr_ok and adds 0..3 cycles of latency per request.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   req, wr, size       request valid, 1=write, access size (informational)
//   wstrb, addr, wdata  byte enables, byte address, write data
//   addr_ok             request accepted this cycle (combinational)
//   data_ok, rdata      registered response pulse and read data
module sram_like_slave #(
    parameter int unsigned AW   = 12,
    parameter int unsigned OUTS = 2,
    parameter int unsigned LAT  = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

`ifdef SRAM_SLV_RAND_DELAY_EN
    localparam int unsigned XDLY = 3;
`else
    localparam int unsigned XDLY = 0;
`endif
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CNTW  = $clog2(OUTS + 1);
    localparam int unsigned PW    = (OUTS > 1) ? $clog2(OUTS) : 1;
    localparam int unsigned CDW   = (LAT + XDLY > 1) ? $clog2(LAT + XDLY) : 1;

    typedef struct packed {
        logic           wr;
        logic [31:0]    data;
        logic [CDW-1:0] cd;
    } entry_t;

    logic [31:0]     mem [DEPTH];
    entry_t          ent [OUTS];
    logic [PW-1:0]   head, tail;
    logic [PW-1:0]   head_inc, tail_inc;
    logic [CNTW-1:0] count, count_nxt;
    logic [AW-1:0]   word_idx;
    logic [31:0]     rd_word;
    logic            retire, accept, stall;
    logic [CDW-1:0]  cd_load;

    // Size and out-of-range address bits carry no meaning for this memory
    logic unused_bits;
    assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

`ifdef SRAM_SLV_RAND_DELAY_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, right-shifting form
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end

    assign stall   = lfsr[0];
    assign cd_load = CDW'(LAT - 1) + CDW'(lfsr[3:2]);
`else
    assign stall   = 1'b0;
    assign cd_load = CDW'(LAT - 1);
`endif

    // Handshake, retire and pointer/occupancy next-state
    always_comb begin
        word_idx  = addr[AW+1:2];
        rd_word   = mem[word_idx];
        retire    = (count != '0) && (ent[head].cd == '0);
        addr_ok   = req && resetn && ((count < CNTW'(OUTS)) || retire) && !stall;
        accept    = addr_ok;
        head_inc  = (head == PW'(OUTS - 1)) ? '0 : head + PW'(1);
        tail_inc  = (tail == PW'(OUTS - 1)) ? '0 : tail + PW'(1);
        count_nxt = count;
        case ({accept, retire})
            2'b10:   count_nxt = count + CNTW'(1);
            2'b01:   count_nxt = count - CNTW'(1);
            default: count_nxt = count;
        endcase
    end

    // Byte-lane write at the handshake edge; contents survive reset
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Pending-response queue and registered response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            data_ok <= 1'b0;
            rdata   <= '0;
            for (int i = 0; i < int'(OUTS); i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(OUTS); i++) begin
                if (ent[i].cd != '0) begin
                    ent[i].cd <= ent[i].cd - CDW'(1);
                end
            end
            if (accept) begin
                // Read data is captured now, so later writes cannot disturb it
                ent[tail].wr   <= wr;
                ent[tail].data <= rd_word;
                ent[tail].cd   <= cd_load;
                tail           <= tail_inc;
            end
            data_ok <= retire;
            rdata   <= (retire && !ent[head].wr) ? ent[head].data : 32'd0;
            if (retire) begin
                head <= head_inc;
            end
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_sram_like_slave.sv
module tb_sram_like_slave;

    localparam int unsigned AW   = 12;
    localparam int unsigned OUTS = 2;
    localparam int unsigned LAT  = 1;
    localparam int unsigned AW3  = 6;
    localparam int unsigned LAT3 = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic        addr_ok3, data_ok3;
    logic [31:0] rdata3;

    always #5 clk = ~clk;

    sram_like_slave #(.AW(AW), .OUTS(OUTS), .LAT(LAT)) u_dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    sram_like_slave #(.AW(AW3), .OUTS(OUTS), .LAT(LAT3)) u_dut3 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok3), .data_ok(data_ok3), .rdata(rdata3)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference: memory image plus expected responses tagged with the
    // clock edge after which each data_ok must be visible.
    logic [31:0] mm [1 << AW];
    logic [31:0] q_data [$];
    int unsigned q_edge [$];
    int unsigned now = 0;
    int unsigned last_resp = 0;
    logic [31:0] last_rd = '0;
    logic        acc = 1'b0;
    logic        s3_ok = 1'b0;
    logic        s3_dok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, check against the model, then step past posedge
    task automatic cycle();
        int unsigned busy;
        logic        exp_ok;
        logic [AW-1:0] idx;
        int unsigned resp;
        @(negedge clk);
        s3_ok  = addr_ok3;
        s3_dok = data_ok3;
        if (data_ok) begin
            last_rd = rdata;
            if (q_data.size() == 0) begin
                chk("spurious_data_ok", 32'(data_ok), 32'd0);
            end else begin
                chk("rdata", rdata, q_data[0]);
`ifndef SRAM_SLV_RAND_DELAY_EN
                chk("resp_cycle", now, q_edge[0]);
`endif
                void'(q_data.pop_front());
                void'(q_edge.pop_front());
            end
        end
`ifndef SRAM_SLV_RAND_DELAY_EN
        else if (q_edge.size() != 0 && q_edge[0] == now) begin
            chk("missing_data_ok", 32'(data_ok), 32'd1);
            void'(q_data.pop_front());
            void'(q_edge.pop_front());
        end
        busy = 0;
        foreach (q_edge[i]) if (q_edge[i] > now + 1) busy++;
        exp_ok = req && (busy < OUTS);
        chk("addr_ok", 32'(addr_ok), 32'(exp_ok));
`endif
        acc = req && addr_ok;
        if (acc) begin
            idx = addr[AW+1:2];
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) mm[idx][8*b +: 8] = wdata[8*b +: 8];
                q_data.push_back(32'd0);
            end else begin
                q_data.push_back(mm[idx]);
            end
            resp = now + 1 + LAT;
            if (resp <= last_resp) resp = last_resp + 1;
            last_resp = resp;
            q_edge.push_back(resp);
        end
        @(posedge clk);
        now++;
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int unsigned n);
        req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 64) begin
            cycle();
            n++;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int unsigned k = 0;
        req = 1'b0;
        while (q_data.size() != 0 && k < 200) begin
            cycle();
            k++;
        end
        chk("drain", q_data.size(), 32'd0);
        cycle();
        cycle();
    endtask

    initial begin
        int unsigned n;
        int unsigned idx;
        logic [31:0] a;
        logic        exp3_ok [5];
        req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0; addr = '0; wdata = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req = 1'b1;
        #1;
        chk("addr_ok_in_reset", 32'(addr_ok), 32'd0);
        chk("reset_data_ok", 32'(data_ok), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        req = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cycle();
        cycle();

        // Full-word write then read of the same word
        issue(1'b1, 32'h1c00_0010, 32'h1234_5678, 4'hF, n);
`ifndef SRAM_SLV_RAND_DELAY_EN
        chk("wr_accept_cycles", n, 32'd1);
`endif
        issue(1'b0, 32'h1c00_0010, 32'h0, 4'h0, n);
        drain();
        chk("read_back", last_rd, 32'h1234_5678);

        // Single byte lane merge
        issue(1'b1, 32'h1c00_0010, 32'hDEAB_BEEF, 4'b0100, n);
        issue(1'b0, 32'h1c00_0010, 32'h0, 4'h0, n);
        drain();
        chk("byte_merge", last_rd, 32'h12AB_5678);

        // Write with no strobes leaves memory untouched but still responds
        issue(1'b1, 32'h1c00_0010, 32'hFFFF_FFFF, 4'h0, n);
        issue(1'b0, 32'h1c00_0010, 32'h0, 4'h0, n);
        drain();
        chk("wstrb0_keep", last_rd, 32'h12AB_5678);

        // Back-to-back reads of words 0..7 with req held high
        for (int i = 0; i < 8; i++) issue(1'b1, 32'(i) << 2, $urandom, 4'hF, n);
        drain();
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 32'(i) << 2, 32'h0, 4'h0, n);
`ifndef SRAM_SLV_RAND_DELAY_EN
            chk("stream_accept", n, 32'd1);
`endif
        end
        drain();

        // Asynchronous reset with responses still pending
        issue(1'b0, 32'h0, 32'h0, 4'h0, n);
        issue(1'b0, 32'h4, 32'h0, 4'h0, n);
        req = 1'b0;
        resetn = 1'b0;
        #1;
        chk("async_rst_data_ok", 32'(data_ok), 32'd0);
        chk("async_rst_rdata", rdata, 32'd0);
        chk("async_rst_data_ok3", 32'(data_ok3), 32'd0);
        chk("async_rst_rdata3", rdata3, 32'd0);
        q_data.delete();
        q_edge.delete();
        repeat (3) begin
            @(posedge clk);
            now++;
        end
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("stale_data_ok3", 32'(s3_dok), 32'd0);
        end

`ifndef SRAM_SLV_RAND_DELAY_EN
        // LAT=3, OUTS=2 with req held: the third accept coincides with the first retire
        exp3_ok[0] = 1'b1; exp3_ok[1] = 1'b1; exp3_ok[2] = 1'b0;
        exp3_ok[3] = 1'b1; exp3_ok[4] = 1'b1;
        req = 1'b1; wr = 1'b0; addr = 32'h0; wstrb = 4'h0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk($sformatf("lat3_addr_ok_c%0d", c), 32'(s3_ok), 32'(exp3_ok[c]));
            chk($sformatf("lat3_data_ok_c%0d", c), 32'(s3_dok), (c == 4) ? 32'd1 : 32'd0);
        end
        drain();
`endif

        // Random traffic over a pre-written window of 16 words
        for (int i = 0; i < 16; i++) issue(1'b1, 32'(i) << 2, $urandom, 4'hF, n);
        drain();
        for (int k = 0; k < 200; k++) begin
            idx = $urandom_range(0, 15);
            a = ($urandom & 32'hFFFF_C003) | (idx << 2);
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), n);
            if ($urandom_range(0, 3) == 0) begin
                req = 1'b0;
                cycle();
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
